// File: rtl/shift_add_mul32.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier with valid/ready on both sides.
// The only arithmetic is two chained gate-level rca32 adders forming a 64-bit accumulator add.

module rca32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out,
    output logic        overflow
);

    logic [32:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign carry_out = carry[32];
    assign overflow  = carry[32] ^ carry[31];

endmodule

module shift_add_mul32 #(
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product,
    output logic [5:0]  out_cycles
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t      state_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] acc_q;
    logic [5:0]  count_q;

    logic [31:0] sum_lo;
    logic [31:0] sum_hi;
    logic        carry_lo;
    logic        carry_hi;
    logic        ovf_lo;
    logic        ovf_hi;
    logic [63:0] acc_sum;
    logic [63:0] acc_next;
    logic        run_last;
    logic        unused_adder_flags;

    rca32 u_rca_lo (
        .a         (acc_q[31:0]),
        .b         (mcand_q[31:0]),
        .carry_in  (1'b0),
        .sum       (sum_lo),
        .carry_out (carry_lo),
        .overflow  (ovf_lo)
    );

    rca32 u_rca_hi (
        .a         (acc_q[63:32]),
        .b         (mcand_q[63:32]),
        .carry_in  (carry_lo),
        .sum       (sum_hi),
        .carry_out (carry_hi),
        .overflow  (ovf_hi)
    );

    // Partial sums never exceed 2^64-1, so the top carry and overflow flags carry no information.
    assign unused_adder_flags = carry_hi ^ ovf_lo ^ ovf_hi;

    assign acc_sum  = {sum_hi, sum_lo};
    assign acc_next = mplier_q[0] ? acc_sum : acc_q;

    // Early exit once the bit being consumed this cycle is the last possibly-set one.
    assign run_last = EARLY_TERM ? (mplier_q[31:1] == 31'd0) : (count_q == 6'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mcand_q     <= 64'd0;
            mplier_q    <= 32'd0;
            acc_q       <= 64'd0;
            count_q     <= 6'd0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_product <= 64'd0;
            out_cycles  <= 6'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        mcand_q  <= {32'd0, in_a};
                        mplier_q <= in_b;
                        acc_q    <= 64'd0;
                        count_q  <= 6'd0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q    <= acc_next;
                    mcand_q  <= {mcand_q[62:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[31:1]};
                    count_q  <= count_q + 6'd1;
                    if (run_last) begin
                        out_product <= acc_next;
                        out_cycles  <= count_q + 6'd1;
                        out_valid   <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul32.sv
// Bench for shift_add_mul32: one instance per EARLY_TERM value, table vectors, corner sequences
// and a random regression, all checked through a per-instance expectation queue.

module tb_shift_add_mul32;

    typedef struct {
        logic [63:0] prod;
        logic [5:0]  cyc;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        logic [5:0]  cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [31:0] in_a        [2];
    logic [31:0] in_b        [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [63:0] out_product [2];
    logic [5:0]  out_cycles  [2];

    int   total = 0;
    int   bad = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    bit   drv_done [2];

    always #5 clk = ~clk;

    // Index 0: EARLY_TERM=1, index 1: EARLY_TERM=0.
    shift_add_mul32 #(.EARLY_TERM(1'b1)) u_dut_et1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_product(out_product[0]), .out_cycles(out_cycles[0])
    );

    shift_add_mul32 #(.EARLY_TERM(1'b0)) u_dut_et0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_product(out_product[1]), .out_cycles(out_cycles[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] n_of(input int sel, input logic [31:0] b);
        logic [5:0] n;
        if (sel == 1) return 6'd32;
        n = 6'd1;
        for (int i = 0; i < 32; i++) if (b[i]) n = 6'(i + 1);
        return n;
    endfunction

    function automatic int sb_size(input int sel);
        return (sel == 0) ? sb0.size() : sb1.size();
    endfunction

    // Output monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (out_valid[s] && out_ready[s]) begin
                    exp_t e;
                    if (sb_size(s) == 0) begin
                        check($sformatf("unexpected_output%0d", s), 64'd1, 64'd0);
                    end else begin
                        e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
                        check($sformatf("product%0d", s), out_product[s], e.prod);
                        check($sformatf("cycles%0d", s), 64'(out_cycles[s]), 64'(e.cyc));
                    end
                end
            end
        end
    end

    // Called at posedge+1. Returns at posedge+1 after accept, or at the negedge out_valid is seen.
    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input logic [5:0] cyc, input bit wait_out,
                         output int lat);
        int   k;
        exp_t e;
        lat = 0;
        in_a[sel] = a;
        in_b[sel] = b;
        in_valid[sel] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready[sel] && k < 300);
        if (!in_ready[sel]) begin
            check($sformatf("accept_timeout%0d", sel), 64'd0, 64'd1);
            in_valid[sel] = 1'b0;
            return;
        end
        e.prod = prod;
        e.cyc  = cyc;
        if (sel == 0) sb0.push_back(e); else sb1.push_back(e);
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        in_a[sel] = $urandom;
        in_b[sel] = $urandom;
        if (!wait_out) return;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[sel] && lat < 100);
    endtask

    task automatic rand_run(input int sel, input int nops);
        fork
            begin
                int          lat;
                logic [31:0] a;
                logic [31:0] b;
                for (int i = 0; i < nops; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    a = $urandom;
                    b = $urandom >> $urandom_range(0, 31);
                    issue(sel, a, b, {32'd0, a} * {32'd0, b}, n_of(sel, b), 1'b1, lat);
                    check($sformatf("rand_latency%0d", sel), 64'(lat), 64'(n_of(sel, b)) + 64'd1);
                    @(posedge clk);
                    #1;
                end
                drv_done[sel] = 1'b1;
            end
            begin
                int cyc = 0;
                while ((!drv_done[sel] || sb_size(sel) > 0) && cyc < 90000) begin
                    @(posedge clk);
                    #1;
                    out_ready[sel] = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                if (cyc >= 90000) check($sformatf("rand_drain%0d", sel), 64'd0, 64'd1);
                out_ready[sel] = 1'b1;
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int   lat;
        bit   saw_valid;

        vecs[0] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 6'd32};
        vecs[1] = '{0, 32'd12345, 32'd5, 64'd61725, 6'd3};
        vecs[2] = '{0, 32'd99, 32'd0, 64'd0, 6'd1};
        vecs[3] = '{0, 32'd3, 32'h8000_0000, 64'h1_8000_0000, 6'd32};
        vecs[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 6'd32};
        vecs[5] = '{1, 32'd3, 32'd0, 64'd0, 6'd32};
        vecs[6] = '{0, 32'd1, 32'd1, 64'd1, 6'd1};
        vecs[7] = '{0, 32'hDEAD_BEEF, 32'd1, 64'hDEAD_BEEF, 6'd1};
        vecs[8] = '{0, 32'd1000, 32'd6, 64'd6000, 6'd3};
        vecs[9] = '{1, 32'd12345, 32'd5, 64'd61725, 6'd32};

        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_a[s]      = 32'd0;
            in_b[s]      = 32'd0;
            out_ready[s] = 1'b1;
            drv_done[s]  = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready", 64'(in_ready[s]), 64'd0);
            check("rst_out_valid", 64'(out_valid[s]), 64'd0);
            check("rst_product", out_product[s], 64'd0);
            check("rst_cycles", 64'(out_cycles[s]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_release", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_first_edge0", 64'(in_ready[0]), 64'd1);
        check("in_ready_first_edge1", 64'(in_ready[1]), 64'd1);

        // Table vectors with latency checks
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].cyc, 1'b1, lat);
            check($sformatf("latency_vec%0d", i), 64'(lat), 64'(vecs[i].cyc) + 64'd1);
            @(posedge clk);
            #1;
        end

        // Backpressure in DONE with new operands offered
        out_ready[0] = 1'b0;
        issue(0, 32'd7, 32'd9, 64'd63, 6'd4, 1'b1, lat);
        check("latency_bp", 64'(lat), 64'd5);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b1;
        in_a[0] = 32'd5;
        in_b[0] = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid[0]), 64'd1);
            check("bp_product", out_product[0], 64'd63);
            check("bp_cycles", 64'(out_cycles[0]), 64'd4);
            check("bp_in_ready", 64'(in_ready[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_rise", 64'(in_ready[0]), 64'd1);
        check("bp_out_valid_drop", 64'(out_valid[0]), 64'd0);
        check("bp_no_capture", 64'(sb_size(0)), 64'd0);

        // Asynchronous reset in the middle of a run
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 6'd32, 1'b0, lat);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb1.delete();
        for (int s = 0; s < 2; s++) begin
            check("abort_in_ready", 64'(in_ready[s]), 64'd0);
            check("abort_out_valid", 64'(out_valid[s]), 64'd0);
            check("abort_product", out_product[s], 64'd0);
            check("abort_cycles", 64'(out_cycles[s]), 64'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_valid = saw_valid | out_valid[1];
        end
        check("abort_no_valid", 64'(saw_valid), 64'd0);
        @(posedge clk);
        #1;
        issue(1, 32'd3, 32'd7, 64'd21, 6'd32, 1'b1, lat);
        check("latency_after_abort", 64'(lat), 64'd33);
        @(posedge clk);
        #1;

        // Random regression on both instances in parallel
        fork
            rand_run(0, 1000);
            rand_run(1, 1000);
        join
        repeat (3) @(posedge clk);
        check("sb0_empty", 64'(sb_size(0)), 64'd0);
        check("sb1_empty", 64'(sb_size(1)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
